counter_arbiter: RTL
====================

Name: counter_arbiter

Overview:
- Round-robin arbiter and sequencer for one shared up-counter resource (8-bit by default).
- NREQ requesters each ask for a counting run of a programmed length.
- The block grants the counter to one requester at a time, runs the count from 0 to the requested length, then pulses done to that requester.
- Sits between client FSMs and the shared count datapath; the count output is what the grantee observes.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, counter and length width in bits

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
req  input  NREQ  per-requester request level; held high until done or abort
len  input  NREQ*WIDTH  per-requester run length; len[i*WIDTH +: WIDTH] belongs to requester i
gnt  output  NREQ  one-hot grant; high while the requester owns the counter (RUN state)
done  output  NREQ  one-cycle completion pulse to the finished requester
count  output  WIDTH  shared counter value
busy  output  1  high when state is not IDLE

Behaviour:
- Reset:
  - Clock and reset fixed: one clock; reset is synchronous and active-high (ports clk, rst).
  - When rst is high at a clock edge: state=IDLE, gnt=0, done=0, count=0, busy=0, ptr=0, mask=0.
  - Reset overrides all other activity, including mid-RUN; no done pulse is issued on reset.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - Eligible requesters are req & ~mask.
  - If any are eligible, pick the first index at or after ptr, searching upward and wrapping NREQ-1 -> 0.
  - At the next edge: state=RUN, gnt[win]=1, count=0, tgt latched from len[win], own=win.
  - mask is cleared at every IDLE edge.
  - If none are eligible, stay in IDLE with count=0.
- RUN:
  - count increments by 1 each cycle.
  - If req[own]=0 (abort): next state IDLE; gnt=0; no done pulse; count=0; ptr=own+1 (mod NREQ).
  - Else if count==tgt: next state DONE; gnt=0; done[own]=1; count holds at tgt; ptr=own+1 (mod NREQ); mask=onehot(own).
  - Abort has priority over completion when both occur in the same cycle.
- DONE:
  - Lasts exactly one cycle; next state IDLE; done=0; count=0.
  - mask hides requester own in the IDLE cycle that follows, so a requester dropping req one cycle after seeing done is not regranted.
- Run-length rules:
  - len=L gives exactly L+1 RUN cycles with count = 0..L.
  - len=0 gives one RUN cycle with count=0.
  - tgt ≤ 2^WIDTH-1, so count never wraps during a run.
- Timing:
  - Request-to-grant latency is 1 cycle from IDLE.
  - Minimum spacing between consecutive grants is 2 cycles (DONE, then IDLE).
- Input stability:
  - Changes to len after the grant edge are ignored.
  - Changes to req of non-owners during RUN affect only the next arbitration.
- Invariants:
  - gnt is zero-or-one-hot.
  - done is zero-or-one-hot.
  - gnt and done are never both high for the same requester.

Test Plan:
- Reset, then req0=1, len0=3:
  - Expect gnt0 high 4 cycles with count 0,1,2,3.
  - Next cycle done0=1 with count=3; following cycle IDLE with count=0, busy=0.
- req0 and req2 rise together, len=1 each, after reset:
  - Expect req0 granted first (ptr=0), done0.
  - req2 granted 2 cycles after done0; ptr ends at 3.
- All four requesters held high continuously, len=0:
  - Grant order is 0,1,2,3,0,... with every grant spaced exactly 3 cycles apart.
  - Requester 0 is not regranted immediately after its own done even though its req stays high.
- req1 len=255 (WIDTH=8):
  - count reaches 255 with no wrap; done1 after 256 RUN cycles.
- Abort:
  - req3 len=10; drop req3 when count=4.
  - Next cycle IDLE, gnt=0, no done pulse, count=0; pending req0 granted on the following edge.
- Reset mid-run:
  - Assert rst during RUN at count=5.
  - Next cycle all outputs 0, state IDLE, no done pulse; after rst drops, req0 is served first (ptr=0).

Source files
------------

// File: rtl/counter_arbiter.sv
// Round-robin arbiter/sequencer for one shared up-counter.
// Grants one requester at a time, counts 0..len, then pulses done to it.
module counter_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   len,
   output logic [NREQ-1:0]         gnt,
   output logic [NREQ-1:0]         done,
   output logic [WIDTH-1:0]        count,
   output logic                    busy
);

   // state  | meaning
   // IDLE   | arbitrate among req & ~mask, starting at ptr
   // RUN    | count owned by 'own', running 0..tgt
   // DONE   | one-cycle completion pulse, then back to IDLE
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam int              PW     = (NREQ > 2) ? $clog2(NREQ) : 1;
   localparam logic [PW:0]     NREQ_W = (PW+1)'(NREQ);
   localparam logic [PW-1:0]   LAST   = PW'(NREQ-1);

   logic [1:0]        state_q, state_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [NREQ-1:0]   done_q, done_d;
   logic [WIDTH-1:0]  count_q, count_d;
   logic              busy_q, busy_d;
   logic [PW-1:0]     ptr_q, ptr_d;
   logic [NREQ-1:0]   mask_q, mask_d;
   logic [PW-1:0]     own_q, own_d;
   logic [WIDTH-1:0]  tgt_q, tgt_d;

   logic [NREQ-1:0]   elig;
   logic              found;
   logic [PW-1:0]     win;
   logic [PW:0]       cand;
   logic [WIDTH-1:0]  len_win;
   logic [PW-1:0]     own_inc;

   // Search upward from ptr with wrap; first eligible index wins.
   always_comb begin
      elig  = req & ~mask_q;
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, ptr_q} + (PW+1)'(k);
         if (cand >= NREQ_W) begin
            cand = cand - NREQ_W;
         end
         if (!found && elig[cand[PW-1:0]]) begin
            found = 1'b1;
            win   = cand[PW-1:0];
         end
      end
   end

   always_comb begin
      len_win = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win == PW'(i)) begin
            len_win = len[i*WIDTH +: WIDTH];
         end
      end
   end

   assign own_inc = (own_q == LAST) ? '0 : own_q + PW'(1);

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      done_d  = '0;
      count_d = count_q;
      busy_d  = busy_q;
      ptr_d   = ptr_q;
      mask_d  = mask_q;
      own_d   = own_q;
      tgt_d   = tgt_q;
      case (state_q)
         S_IDLE: begin
            mask_d  = '0;
            count_d = '0;
            gnt_d   = '0;
            busy_d  = 1'b0;
            if (found) begin
               state_d = S_RUN;
               gnt_d   = NREQ'(1) << win;
               tgt_d   = len_win;
               own_d   = win;
               busy_d  = 1'b1;
            end
         end
         S_RUN: begin
            // Abort wins over completion in the same cycle.
            if (!req[own_q]) begin
               state_d = S_IDLE;
               gnt_d   = '0;
               count_d = '0;
               ptr_d   = own_inc;
               busy_d  = 1'b0;
            end else if (count_q == tgt_q) begin
               state_d = S_DONE;
               gnt_d   = '0;
               done_d  = NREQ'(1) << own_q;
               ptr_d   = own_inc;
               mask_d  = NREQ'(1) << own_q;
            end else begin
               count_d = count_q + WIDTH'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            count_d = '0;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            gnt_d   = '0;
            count_d = '0;
            busy_d  = 1'b0;
            mask_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         gnt_q   <= '0;
         done_q  <= '0;
         count_q <= '0;
         busy_q  <= 1'b0;
         ptr_q   <= '0;
         mask_q  <= '0;
         own_q   <= '0;
         tgt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         count_q <= count_d;
         busy_q  <= busy_d;
         ptr_q   <= ptr_d;
         mask_q  <= mask_d;
         own_q   <= own_d;
         tgt_q   <= tgt_d;
      end
   end

   assign gnt   = gnt_q;
   assign done  = done_q;
   assign count = count_q;
   assign busy  = busy_q;

endmodule
